// File: rtl/core_harness_ctrl.sv
// Bench-side core harness: loads a program image from the host, releases
// the core, serves exIns reads with RD_LAT latency, halts on bp/timeout.
//
// Ports:
//   clk, nrst                : clock, synchronous active-low reset
//   ld_valid/ld_data/ld_last : host program stream (ld_ready back-pressure)
//   core_nrst                : active-low reset to the core
//   exIns_ren/exIns_addr     : core instruction read request
//   exIns_valid/exIns_in     : read response, in order, RD_LAT cycles later
//   pc, bp_en, bp_addr       : PC breakpoint supervision
//   timeout                  : run-cycle limit, 0 disables
//   halt/halt_cause/hit_idx  : sticky halt status
//   cycle_count/load_count   : run cycles elapsed, words loaded
module core_harness_ctrl #(
  parameter int XLEN = 32,
  parameter int DEPTH = 256,
  parameter int NUM_BP = 4,
  parameter int RD_LAT = 1,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013),
  localparam int AW = $clog2(DEPTH),
  localparam int HIW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   ld_valid,
  input  logic [XLEN-1:0]        ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   core_nrst,
  input  logic                   exIns_ren,
  input  logic [XLEN-1:0]        exIns_addr,
  output logic                   exIns_valid,
  output logic [XLEN-1:0]        exIns_in,
  input  logic [XLEN-1:0]        pc,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*XLEN-1:0] bp_addr,
  input  logic [31:0]            timeout,
  output logic                   halt,
  output logic [1:0]             halt_cause,
  output logic [HIW-1:0]         hit_idx,
  output logic [31:0]            cycle_count,
  output logic [AW:0]            load_count
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [AW:0]       lc_q, lc_d;
  logic [31:0]       cyc_q, cyc_d;
  logic              halt_q, halt_d;
  logic [1:0]        cause_q, cause_d;
  logic [HIW-1:0]    hit_q, hit_d;
  logic              cnrst_q, cnrst_d;

  logic [XLEN-1:0]   mem [DEPTH];
  logic              ld_fire;
  logic              bp_hit;
  logic [HIW-1:0]    bp_idx;
  logic              to_hit;

  logic              req;
  logic [AW-1:0]     rd_idx;
  logic [XLEN-1:0]   rd_lim;
  logic [XLEN-1:0]   rd_word;
  logic [RD_LAT-1:0] vld_q;
  logic [XLEN-1:0]   dat_q [RD_LAT];

  assign ld_ready = nrst && (state_q == S_LOAD);
  assign ld_fire  = ld_valid && ld_ready;
  assign core_nrst = nrst && cnrst_q;

  // Scan high to low so the lowest enabled match wins.
  always_comb begin
    bp_hit = 1'b0;
    bp_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc == bp_addr[i*XLEN +: XLEN])) begin
        bp_hit = 1'b1;
        bp_idx = HIW'(i);
      end
    end
  end

  assign to_hit = (timeout != 32'd0) &&
                  (cyc_q == timeout - 32'd1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lc_d    = lc_q;
    cyc_d   = cyc_q;
    halt_d  = halt_q;
    cause_d = cause_q;
    hit_d   = hit_q;
    cnrst_d = cnrst_q;
    unique case (state_q)
      S_LOAD: begin
        if (ld_fire) begin
          ptr_d = ptr_q + 1'b1;
          lc_d  = lc_q + 1'b1;
          if (ld_last) begin
            state_d = S_RUN;
            cnrst_d = 1'b1;
          end else if (ptr_q == AW'(DEPTH - 1)) begin
            state_d = S_HALT;
            halt_d  = 1'b1;
            cause_d = 2'd3;
          end
        end
      end
      S_RUN: begin
        cyc_d = cyc_q + 32'd1;
        if (bp_hit) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          cause_d = 2'd1;
          hit_d   = bp_idx;
        end else if (to_hit) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          cause_d = 2'd2;
        end
      end
      S_HALT: ;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      lc_q    <= '0;
      cyc_q   <= '0;
      halt_q  <= 1'b0;
      cause_q <= 2'd0;
      hit_q   <= '0;
      cnrst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lc_q    <= lc_d;
      cyc_q   <= cyc_d;
      halt_q  <= halt_d;
      cause_q <= cause_d;
      hit_q   <= hit_d;
      cnrst_q <= cnrst_d;
    end
  end

  // Image buffer survives reset so a reload can overwrite it in place.
  always_ff @(posedge clk) begin
    if (ld_fire) mem[ptr_q] <= ld_data;
  end

  // Byte-address compare against load_count*4 also rejects >= DEPTH*4.
  assign req     = exIns_ren && (state_q == S_RUN);
  assign rd_idx  = exIns_addr[AW+1:2];
  assign rd_lim  = XLEN'({lc_q, 2'b00});
  assign rd_word = (exIns_addr < rd_lim) ? mem[rd_idx] : NOP_INST;

  // Last stage only loads on a valid beat so exIns_in holds between hits.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= req;
      if (RD_LAT > 1 || req) dat_q[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (i < RD_LAT - 1 || vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign exIns_valid = vld_q[RD_LAT-1];
  assign exIns_in    = dat_q[RD_LAT-1];
  assign halt        = halt_q;
  assign halt_cause  = cause_q;
  assign hit_idx     = hit_q;
  assign cycle_count = cyc_q;
  assign load_count  = lc_q;

endmodule
